// File: rtl/fmac_prim_seq_detect.sv
// -----------------------------------------------------------------------------
// fmac_prim_seq_detect
//
// Primitive-sequence recogniser for the FC MAC receive path. Every cycle it
// takes SLOTS decoded transmission words (slot 0 earliest). For each of NPRIM
// primitive types it tracks the current run of consecutive instances. When a
// run reaches THRESH instances it raises a registered one-cycle recognition
// pulse. It also reports whether a recognised run is still in progress, and
// when such a run ends.
//
// Optional feature macro: FMAC_PRIM_STATS_EN
//   Defined   -> adds stats_clr and prim_evt_cnt. These are per-primitive
//                saturating counters of prim_event pulses.
//   Undefined -> those ports and the counter logic are absent.
//
// Ports
//   clk          in   core clock
//   rst_n        in   asynchronous active-low reset
//   prim_hit     in   [NPRIM*SLOTS] hit for primitive p in slot s at bit p*SLOTS+s
//   prim_val     in   slots carry valid words this cycle
//   prim_event   out  [NPRIM] one-cycle pulse: run of p recognised
//   prim_active  out  [NPRIM] level: recognised run of p in progress
//   prim_end     out  [NPRIM] one-cycle pulse: recognised run of p terminated
//   stats_clr    in   synchronous clear of all counters (stats build only)
//   prim_evt_cnt out  [NPRIM*STAT_W] saturating event counters (stats build only)
// -----------------------------------------------------------------------------
module fmac_prim_seq_detect #(
  parameter int SLOTS  = 2,
  parameter int NPRIM  = 4,
  parameter int THRESH = 3,
  parameter int REARM  = 0,
  parameter int STAT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NPRIM*SLOTS-1:0]  prim_hit,
  input  logic                    prim_val,
  output logic [NPRIM-1:0]        prim_event,
  output logic [NPRIM-1:0]        prim_active,
  output logic [NPRIM-1:0]        prim_end
`ifdef FMAC_PRIM_STATS_EN
  ,
  input  logic                    stats_clr,
  output logic [NPRIM*STAT_W-1:0] prim_evt_cnt
`endif
);

  localparam logic [3:0] THRESH_CNT = 4'(THRESH);

  // THRESH >= SLOTS limits each primitive to one event and one end per cycle.
  // That limit is what lets the outputs be single bits.
  if (THRESH < 2 || THRESH > 15 || THRESH < SLOTS || STAT_W < 1) begin : g_bad_param
    $error("fmac_prim_seq_detect: illegal THRESH/SLOTS/STAT_W combination");
  end

  logic [NPRIM-1:0][3:0] run_cnt;
  logic [NPRIM-1:0][3:0] run_cnt_nxt;
  logic [NPRIM-1:0]      active_nxt;
  logic [NPRIM-1:0]      event_nxt;
  logic [NPRIM-1:0]      end_nxt;
  logic [SLOTS-1:0]      slot_multi;

  // A slot that claims more than one primitive is corrupt. Such a slot is a
  // non-match for every primitive, so it breaks all runs.
  always_comb begin : p_slot_multi
    logic seen;
    // NOTE: every variable gets a value at the top of the block. Assigning on
    // every path is what stops always_comb from inferring a latch.
    slot_multi = '0;
    seen       = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      seen = 1'b0;
      for (int q = 0; q < NPRIM; q++) begin
        if (prim_hit[q*SLOTS+s]) begin
          if (seen) slot_multi[s] = 1'b1;
          seen = 1'b1;
        end
      end
    end
  end

  // Per-primitive chain through the slots in time order. The working copies
  // carry the state from slot to slot within a single cycle.
  always_comb begin : p_next
    logic [3:0] cnt;
    logic       act;
    logic       ev;
    logic       en;
    logic       match;
    run_cnt_nxt = run_cnt;
    active_nxt  = prim_active;
    event_nxt   = '0;
    end_nxt     = '0;
    cnt   = '0;
    act   = 1'b0;
    ev    = 1'b0;
    en    = 1'b0;
    match = 1'b0;
    for (int p = 0; p < NPRIM; p++) begin
      // NOTE: blocking assignments here are intentional. Each slot must see
      // the count left by the slot before it, within the same cycle.
      cnt = run_cnt[p];
      act = prim_active[p];
      ev  = 1'b0;
      en  = 1'b0;
      for (int s = 0; s < SLOTS; s++) begin
        match = prim_hit[p*SLOTS+s] && !slot_multi[s];
        if (match) begin
          // With REARM=0 the count parks at THRESH. Further matches then do
          // nothing until the run breaks.
          if (cnt < THRESH_CNT) begin
            cnt = cnt + 4'd1;
            if (cnt == THRESH_CNT) begin
              ev  = 1'b1;
              act = 1'b1;
              if (REARM != 0) cnt = 4'd0;
            end
          end
        end else begin
          cnt = 4'd0;
          if (act) begin
            en  = 1'b1;
            act = 1'b0;
          end
        end
      end
      // An invalid cycle carries no words: state holds and no pulses are issued.
      if (prim_val) begin
        run_cnt_nxt[p] = cnt;
        active_nxt[p]  = act;
        event_nxt[p]   = ev;
        end_nxt[p]     = en;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the run counters are a small flop array, not a RAM, so they are
      // reset. A reset taken mid-run must not leave a partial run behind.
      run_cnt     <= '0;
      prim_event  <= '0;
      prim_active <= '0;
      prim_end    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples values from before the clock edge.
      run_cnt     <= run_cnt_nxt;
      prim_event  <= event_nxt;
      prim_active <= active_nxt;
      prim_end    <= end_nxt;
    end
  end

`ifdef FMAC_PRIM_STATS_EN
  logic [NPRIM-1:0][STAT_W-1:0] evt_cnt;

  // Counters update from the registered pulse, one cycle after prim_event.
  // Clear takes priority over a simultaneous increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_cnt <= '0;
    end else begin
      for (int p = 0; p < NPRIM; p++) begin
        if (stats_clr) begin
          evt_cnt[p] <= '0;
        end else if (prim_event[p] && (evt_cnt[p] != {STAT_W{1'b1}})) begin
          evt_cnt[p] <= evt_cnt[p] + STAT_W'(1);
        end
      end
    end
  end

  assign prim_evt_cnt = evt_cnt;
`endif

endmodule

// File: tb/tb_fmac_prim_seq_detect.sv
// -----------------------------------------------------------------------------
// tb_fmac_prim_seq_detect
//
// Bench for fmac_prim_seq_detect. It drives two instances:
//   dut_a : default parameters (REARM=0)
//   dut_b : REARM=1, STAT_W=2 (the counters exist only with FMAC_PRIM_STATS_EN)
// Hit bit layout for SLOTS=2: NOS = bits 1:0, OLS = bits 3:2, LR = bits 5:4,
// LRR = bits 7:6 (the lower bit of each pair is slot 0).
// -----------------------------------------------------------------------------
module tb_fmac_prim_seq_detect;

  typedef struct packed {
    logic [7:0] hit;
    logic       val;
    logic [3:0] ev;
    logic [3:0] act;
    logic [3:0] en;
  } step_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] hit_a, hit_b;
  logic       val_a, val_b;
  logic [3:0] event_a, active_a, end_a;
  logic [3:0] event_b, active_b, end_b;
`ifdef FMAC_PRIM_STATS_EN
  logic       stats_clr_a, stats_clr_b;
  logic [63:0] cnt_a;
  logic [7:0]  cnt_b;
`endif

  logic [11:0] sb_a[$];
  logic [11:0] sb_b[$];
  int n_cmp = 0;
  int n_err = 0;

  fmac_prim_seq_detect dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .prim_hit    (hit_a),
    .prim_val    (val_a),
    .prim_event  (event_a),
    .prim_active (active_a),
    .prim_end    (end_a)
`ifdef FMAC_PRIM_STATS_EN
    ,
    .stats_clr   (stats_clr_a),
    .prim_evt_cnt(cnt_a)
`endif
  );

  fmac_prim_seq_detect #(.REARM(1), .STAT_W(2)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .prim_hit    (hit_b),
    .prim_val    (val_b),
    .prim_event  (event_b),
    .prim_active (active_b),
    .prim_end    (end_b)
`ifdef FMAC_PRIM_STATS_EN
    ,
    .stats_clr   (stats_clr_b),
    .prim_evt_cnt(cnt_b)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs are applied on the falling edge. Outputs are sampled 1 time unit
  // after the rising edge that consumed those inputs.
  task automatic drive_a(input logic [7:0] hit, input logic val);
    @(negedge clk);
    hit_a = hit;
    val_a = val;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic [7:0] hit, input logic val, input logic clr);
    @(negedge clk);
    hit_b = hit;
    val_b = val;
`ifdef FMAC_PRIM_STATS_EN
    stats_clr_b = clr;
`else
    if (clr) begin end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [23:0] got;
    rst_n = 1'b0;
    hit_a = '0; val_a = 1'b0;
    hit_b = '0; val_b = 1'b0;
`ifdef FMAC_PRIM_STATS_EN
    stats_clr_a = 1'b0;
    stats_clr_b = 1'b0;
`endif
    #3;
    got = {event_a, active_a, end_a, event_b, active_b, end_b};
    n_cmp++;
    if (got !== 24'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %06h required 000000", got);
    end
`ifdef FMAC_PRIM_STATS_EN
    n_cmp++;
    if (cnt_b !== 8'h0) begin
      n_err++;
      $display("FAIL reset_counters: got %02h required 00", cnt_b);
    end
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // NOS recognised on the third instance, later NOS adds nothing, an OLS word
  // ends the NOS run and leaves OLS at a count of 1, and an invalid cycle holds state.
  task automatic test_recognise;
    step_t t [9] = '{
      '{8'h03, 1'b1, 4'h0, 4'h0, 4'h0},
      '{8'h03, 1'b1, 4'h1, 4'h1, 4'h0},
      '{8'h03, 1'b1, 4'h0, 4'h1, 4'h0},
      '{8'h03, 1'b1, 4'h0, 4'h1, 4'h0},
      '{8'h09, 1'b1, 4'h0, 4'h0, 4'h1},
      '{8'h0C, 1'b1, 4'h2, 4'h2, 4'h0},
      '{8'h0C, 1'b0, 4'h0, 4'h2, 4'h0},
      '{8'h00, 1'b1, 4'h0, 4'h0, 4'h2},
      '{8'h00, 1'b1, 4'h0, 4'h0, 4'h0}
    };
    logic [11:0] got, want;
    foreach (t[i]) begin
      sb_a.push_back({t[i].ev, t[i].act, t[i].en});
      drive_a(t[i].hit, t[i].val);
      want = sb_a.pop_front();
      got  = {event_a, active_a, end_a};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL recognise step %0d: got ev/act/end %03h required %03h", i, got, want);
      end
    end
  endtask

  // Invalid cycles pause an LRR run without breaking it. The invalid cycles
  // still carry LRR hits, and those hits must be ignored. A multi-hot slot
  // must break the run.
  task automatic test_gap_multi;
    step_t t [10] = '{
      '{8'hC0, 1'b1, 4'h0, 4'h0, 4'h0},
      '{8'hC0, 1'b0, 4'h0, 4'h0, 4'h0},
      '{8'hC0, 1'b0, 4'h0, 4'h0, 4'h0},
      '{8'hC0, 1'b0, 4'h0, 4'h0, 4'h0},
      '{8'hC0, 1'b0, 4'h0, 4'h0, 4'h0},
      '{8'hC0, 1'b1, 4'h8, 4'h8, 4'h0},
      '{8'h00, 1'b1, 4'h0, 4'h0, 4'h8},
      '{8'hC0, 1'b1, 4'h0, 4'h0, 4'h0},
      '{8'hC1, 1'b1, 4'h0, 4'h0, 4'h0},
      '{8'h40, 1'b1, 4'h0, 4'h0, 4'h0}
    };
    logic [11:0] got, want;
    foreach (t[i]) begin
      sb_a.push_back({t[i].ev, t[i].act, t[i].en});
      drive_a(t[i].hit, t[i].val);
      want = sb_a.pop_front();
      got  = {event_a, active_a, end_a};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL gap_multi step %0d: got ev/act/end %03h required %03h", i, got, want);
      end
    end
  endtask

  // REARM=1: six LR words in a row give an event on the 3rd and the 6th.
  task automatic test_rearm;
    step_t t [4] = '{
      '{8'h30, 1'b1, 4'h0, 4'h0, 4'h0},
      '{8'h30, 1'b1, 4'h4, 4'h4, 4'h0},
      '{8'h30, 1'b1, 4'h4, 4'h4, 4'h0},
      '{8'h00, 1'b1, 4'h0, 4'h0, 4'h4}
    };
    logic [11:0] got, want;
    foreach (t[i]) begin
      sb_b.push_back({t[i].ev, t[i].act, t[i].en});
      drive_b(t[i].hit, t[i].val, 1'b0);
      want = sb_b.pop_front();
      got  = {event_b, active_b, end_b};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL rearm step %0d: got ev/act/end %03h required %03h", i, got, want);
      end
    end
  endtask

  // Reset taken during an active LR run clears everything at once and issues
  // no end pulse. A fresh LR run is then recognised normally.
  task automatic test_reset_mid_run;
    step_t pre [2] = '{
      '{8'h30, 1'b1, 4'h0, 4'h0, 4'h0},
      '{8'h30, 1'b1, 4'h4, 4'h4, 4'h0}
    };
    step_t post [4] = '{
      '{8'h00, 1'b1, 4'h0, 4'h0, 4'h0},
      '{8'h20, 1'b1, 4'h0, 4'h0, 4'h0},
      '{8'h30, 1'b1, 4'h4, 4'h4, 4'h0},
      '{8'h00, 1'b1, 4'h0, 4'h0, 4'h4}
    };
    logic [11:0] got, want;
    foreach (pre[i]) begin
      sb_a.push_back({pre[i].ev, pre[i].act, pre[i].en});
      drive_a(pre[i].hit, pre[i].val);
      want = sb_a.pop_front();
      got  = {event_a, active_a, end_a};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL reset_mid_run pre %0d: got ev/act/end %03h required %03h", i, got, want);
      end
    end
    @(negedge clk);
    hit_a = 8'h30;
    val_a = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    got = {event_a, active_a, end_a};
    n_cmp++;
    if (got !== 12'h0) begin
      n_err++;
      $display("FAIL reset_mid_run async_clear: got %03h required 000", got);
    end
    hit_a = 8'h00;
    val_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    foreach (post[i]) begin
      sb_a.push_back({post[i].ev, post[i].act, post[i].en});
      drive_a(post[i].hit, post[i].val);
      want = sb_a.pop_front();
      got  = {event_a, active_a, end_a};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL reset_mid_run post %0d: got ev/act/end %03h required %03h", i, got, want);
      end
    end
  endtask

`ifdef FMAC_PRIM_STATS_EN
  // dut_b (REARM=1, STAT_W=2): 15 NOS instances give events at instances
  // 3, 6, 9, 12 and 15, and the counter saturates at 3. A clear issued in
  // the same cycle as an event pulse must win.
  task automatic test_stats;
    logic [7:0] hits [9] = '{8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h01, 8'h00};
    logic [1:0] exp_cnt [9] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    drive_b(8'h00, 1'b0, 1'b1);
    foreach (hits[i]) begin
      sb_b.push_back({6'h0, exp_cnt[i], 4'h0});
      drive_b(hits[i], (i < 8) ? 1'b1 : 1'b0, 1'b0);
      n_cmp++;
      if (cnt_b[1:0] !== sb_b[0][5:4]) begin
        n_err++;
        $display("FAIL stats_saturate step %0d: got cnt %0d required %0d", i, cnt_b[1:0], sb_b[0][5:4]);
      end
      void'(sb_b.pop_front());
    end
    drive_b(8'h03, 1'b1, 1'b0);
    drive_b(8'h01, 1'b1, 1'b0);
    n_cmp++;
    if (event_b[0] !== 1'b1) begin
      n_err++;
      $display("FAIL stats_clr_setup: got event %b required 1", event_b[0]);
    end
    drive_b(8'h00, 1'b0, 1'b1);
    n_cmp++;
    if (cnt_b[1:0] !== 2'd0) begin
      n_err++;
      $display("FAIL stats_clr_wins: got cnt %0d required 0", cnt_b[1:0]);
    end
    drive_b(8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (cnt_b[1:0] !== 2'd0) begin
      n_err++;
      $display("FAIL stats_clr_hold: got cnt %0d required 0", cnt_b[1:0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_recognise();
    test_gap_multi();
    test_rearm();
    test_reset_mid_run();
`ifdef FMAC_PRIM_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
